// File: rtl/red_pitaya_dac_pkg.sv
// ---------------------------------------------------------------------------
// red_pitaya_dac_pkg
// Shared definitions for the Red Pitaya DAC DDR transmit path:
//   - dac_mode_e : source select encoding (STREAM / RAMP / TOGGLE / MIDSCALE)
//   - CNT_W      : width of the saturating underflow counter
//   - pattern helpers returning 16-bit words whose low w bits hold the
//     1010..., 0101... and mid-scale values for a w-bit sample
// ---------------------------------------------------------------------------
package red_pitaya_dac_pkg;

  typedef enum logic [1:0] {
    MODE_STREAM   = 2'd0,
    MODE_RAMP     = 2'd1,
    MODE_TOGGLE   = 2'd2,
    MODE_MIDSCALE = 2'd3
  } dac_mode_e;

  localparam int CNT_W = 16;

  // 1010... pattern: every odd bit below w is set (0x2AAA for w = 14).
  function automatic logic [15:0] toggle_hi_pattern(input int w);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if ((b < w) && ((b % 2) == 1)) r[b] = 1'b1;
    end
    return r;
  endfunction

  // 0101... pattern: every even bit below w is set (0x1555 for w = 14).
  function automatic logic [15:0] toggle_lo_pattern(input int w);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if ((b < w) && ((b % 2) == 0)) r[b] = 1'b1;
    end
    return r;
  endfunction

  // Mid-scale code 1 << (w-1) (0x2000 for w = 14).
  function automatic logic [15:0] midscale_pattern(input int w);
    logic [15:0] r;
    r = '0;
    r[w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/dac_pattern_gen.sv
// ---------------------------------------------------------------------------
// dac_pattern_gen
// Built-in test pattern source for the DAC transmit path.
//   aclk     : clock
//   areset   : synchronous, active-high reset
//   cfg_mode : source select (dac_mode_e encoding)
//   pat_0    : ch0 pattern sample for the next S1 load
//   pat_1    : ch1 pattern sample for the next S1 load
// The ramp counter and toggle phase are held at zero whenever their mode is
// not selected, so entering RAMP always starts at 0 and entering TOGGLE
// always starts with the 1010... value on the very first load.
// ---------------------------------------------------------------------------
module dac_pattern_gen
  import red_pitaya_dac_pkg::*;
#(
  parameter int W = 14
) (
  input  logic         aclk,
  input  logic         areset,
  input  logic [1:0]   cfg_mode,
  output logic [W-1:0] pat_0,
  output logic [W-1:0] pat_1
);

  localparam logic [15:0]  TOG_HI_F = toggle_hi_pattern(W);
  localparam logic [15:0]  TOG_LO_F = toggle_lo_pattern(W);
  localparam logic [15:0]  MID_F    = midscale_pattern(W);
  localparam logic [W-1:0] TOG_HI   = TOG_HI_F[W-1:0];
  localparam logic [W-1:0] TOG_LO   = TOG_LO_F[W-1:0];
  localparam logic [W-1:0] MID      = MID_F[W-1:0];

  dac_mode_e    mode;
  logic [W-1:0] ramp_q, ramp_d;
  logic         phase_q, phase_d;

  assign mode = dac_mode_e'(cfg_mode);

  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    ramp_d  = '0;
    phase_d = 1'b0;
    if (mode == MODE_RAMP)   ramp_d  = ramp_q + 1'b1;  // wraps 2^W-1 -> 0
    if (mode == MODE_TOGGLE) phase_d = ~phase_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge aclk) begin
    if (areset) begin
      ramp_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      ramp_q  <= ramp_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    pat_0 = MID;
    pat_1 = MID;
    unique case (mode)
      MODE_RAMP: begin
        pat_0 = ramp_q;
        pat_1 = ~ramp_q;
      end
      MODE_TOGGLE: begin
        pat_0 = phase_q ? TOG_LO : TOG_HI;
        pat_1 = phase_q ? TOG_HI : TOG_LO;
      end
      default: ;  // STREAM ignores the pattern, MIDSCALE uses the default
    endcase
  end

endmodule

// File: rtl/axis_red_pitaya_dac_ddr.sv
// ---------------------------------------------------------------------------
// axis_red_pitaya_dac_ddr
// Two-channel DAC transmit path: AXI4-Stream slave or built-in pattern
// source, split into even/odd halves and driven as DDR buses.
//   aclk, areset     : clock, synchronous active-high reset
//   cfg_mode         : 0 STREAM, 1 RAMP, 2 TOGGLE, 3 MIDSCALE
//   cnt_clear        : one-cycle pulse clearing underflow_count (wins over
//                      a coincident underflow)
//   s_axis_*         : stream slave; ch0 = tdata[W-1:0], ch1 = tdata[16+:W]
//   dac_dat_out_0/1  : DDR pins; even sample bits while aclk is high,
//                      odd sample bits while aclk is low
//   underflow_count  : saturating count of STREAM cycles without a beat
// Pipeline: S1 smp (beat/pattern) -> S2 rise/fall -> output DDR register.
// Sample width W = 2*DDR_DATA_WIDTH must not exceed 16.
// ---------------------------------------------------------------------------
module axis_red_pitaya_dac_ddr
  import red_pitaya_dac_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = 7
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [1:0]                cfg_mode,
  input  logic                      cnt_clear,
  input  logic [31:0]               s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [DDR_DATA_WIDTH-1:0] dac_dat_out_0,
  output logic [DDR_DATA_WIDTH-1:0] dac_dat_out_1,
  output logic [CNT_W-1:0]          underflow_count
);

  localparam int DW = DDR_DATA_WIDTH;
  localparam int W  = 2 * DDR_DATA_WIDTH;

  dac_mode_e             mode;
  logic                  beat;
  logic [W-1:0]          pat_0, pat_1;
  logic [1:0][W-1:0]     smp_q, smp_d;
  logic [1:0][DW-1:0]    rise_q, rise_d, fall_q, fall_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0][DW-1:0]    pin;

  assign mode          = dac_mode_e'(cfg_mode);
  assign s_axis_tready = (mode == MODE_STREAM) && !areset;
  assign beat          = s_axis_tvalid && s_axis_tready;

  if (W < 16) begin : g_tdata_unused
    logic tdata_unused;
    assign tdata_unused = ^{s_axis_tdata[31:16+W], s_axis_tdata[15:W]};
  end

  dac_pattern_gen #(.W(W)) u_pattern (
    .aclk     (aclk),
    .areset   (areset),
    .cfg_mode (cfg_mode),
    .pat_0    (pat_0),
    .pat_1    (pat_1)
  );

  // S1 source select and underflow accounting.
  always_comb begin
    smp_d = smp_q;
    cnt_d = cnt_q;
    if (mode == MODE_STREAM) begin
      if (beat) begin
        smp_d[0] = s_axis_tdata[W-1:0];
        smp_d[1] = s_axis_tdata[16 +: W];
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      smp_d[0] = pat_0;
      smp_d[1] = pat_1;
    end
    if (cnt_clear) cnt_d = '0;
  end

  // S2 even/odd split.
  always_comb begin
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < DW; j++) begin
        rise_d[i][j] = smp_q[i][2*j];
        fall_d[i][j] = smp_q[i][2*j+1];
      end
    end
  end

  // NOTE: the sample registers are datapath, but the reset clears them too so
  // the DAC never replays a stale sample after reset is released.
  always_ff @(posedge aclk) begin
    if (areset) begin
      smp_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
      cnt_q  <= '0;
    end else begin
      smp_q  <= smp_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign underflow_count = cnt_q;

  // Behavioural equivalent of an ODDR in SAME_EDGE / SYNC mode with CE = 1,
  // S = 0: both halves are captured on the rising edge, Q1 drives the high
  // phase and Q2 the low phase.
  for (genvar i = 0; i < 2; i++) begin : g_ch
    for (genvar j = 0; j < DW; j++) begin : g_oddr
      logic q1_q, q2_q;
      always_ff @(posedge aclk) begin
        if (areset) begin
          q1_q <= 1'b0;
          q2_q <= 1'b0;
        end else begin
          q1_q <= rise_q[i][j];
          q2_q <= fall_q[i][j];
        end
      end
      assign pin[i][j] = aclk ? q1_q : q2_q;
    end
  end

  assign dac_dat_out_0 = pin[0];
  assign dac_dat_out_1 = pin[1];

endmodule

// File: tb/tb_axis_red_pitaya_dac_ddr.sv
// ---------------------------------------------------------------------------
// tb_axis_red_pitaya_dac_ddr
// The driver applies inputs, advances a sample-level reference model and
// pushes the expected pin sample pair and underflow count for each rising
// edge into a queue. An independent monitor reassembles the DDR pins of each
// cycle (high phase = even bits, low phase = odd bits) and compares.
// ---------------------------------------------------------------------------
module tb_axis_red_pitaya_dac_ddr;

  localparam int DW   = 7;
  localparam int W    = 2 * DW;
  localparam int MASK = (1 << W) - 1;

  logic          aclk = 1'b0;
  logic          areset;
  logic [1:0]    cfg_mode;
  logic          cnt_clear;
  logic [31:0]   s_axis_tdata;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [DW-1:0] dac_dat_out_0, dac_dat_out_1;
  logic [15:0]   underflow_count;

  axis_red_pitaya_dac_ddr #(.DDR_DATA_WIDTH(DW)) dut (
    .aclk            (aclk),
    .areset          (areset),
    .cfg_mode        (cfg_mode),
    .cnt_clear       (cnt_clear),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .dac_dat_out_0   (dac_dat_out_0),
    .dac_dat_out_1   (dac_dat_out_1),
    .underflow_count (underflow_count)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    int s0;
    int s1;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (sample level) ----------------
  int m_s0 = 0, m_s1 = 0, m_cnt = 0;
  int m_prev = -1;          // mode of previous non-reset cycle, -1 after reset
  int m_ramp = 0, m_ph = 0;
  int h1_s0 = 0, h1_s1 = 0; // S1 value one edge back
  int h2_s0 = 0, h2_s1 = 0; // S1 value two edges back
  bit h1_rst = 1'b1;

  function automatic int tog(input int phase);
    int r = 0;
    for (int b = 0; b < W; b++) if ((b % 2) == (phase ? 0 : 1)) r += (1 << b);
    return r;
  endfunction

  // One clock: check ready, advance model for this edge, push expectation.
  task automatic cycle();
    exp_t e;
    int   md;
    #1;
    md = int'(cfg_mode);
    check("tready", int'(s_axis_tready), (md == 0 && !areset) ? 1 : 0);
    if (areset) begin
      m_s0 = 0; m_s1 = 0; m_cnt = 0; m_prev = -1; m_ramp = 0; m_ph = 0;
    end else begin
      case (md)
        0: begin
          if (s_axis_tvalid) begin
            m_s0 = int'(s_axis_tdata) & MASK;
            m_s1 = int'(s_axis_tdata >> 16) & MASK;
          end else if (m_cnt < 65535) begin
            m_cnt++;
          end
        end
        1: begin
          m_ramp = (m_prev != 1) ? 0 : (m_ramp + 1) % (1 << W);
          m_s0 = m_ramp;
          m_s1 = MASK - m_ramp;
        end
        2: begin
          m_ph = (m_prev != 2) ? 0 : 1 - m_ph;
          m_s0 = tog(m_ph);
          m_s1 = tog(1 - m_ph);
        end
        default: begin
          m_s0 = 1 << (W - 1);
          m_s1 = 1 << (W - 1);
        end
      endcase
      if (cnt_clear) m_cnt = 0;
      m_prev = md;
    end
    // Pins after this edge carry the S1 value from two edges back, unless a
    // reset in this or the previous cycle flushed the pipeline.
    e.s0  = (areset || h1_rst) ? 0 : h2_s0;
    e.s1  = (areset || h1_rst) ? 0 : h2_s1;
    e.cnt = m_cnt;
    sb_q.push_back(e);
    h2_s0 = h1_s0; h2_s1 = h1_s1;
    h1_s0 = m_s0;  h1_s1 = m_s1;
    h1_rst = areset;
    @(posedge aclk);
    #2;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // ---------------- monitor ----------------
  function automatic int reassemble(input logic [DW-1:0] hi, input logic [DW-1:0] lo);
    int r = 0;
    for (int j = 0; j < DW; j++) begin
      if (hi[j] === 1'b1) r += (1 << (2 * j));
      else if (hi[j] !== 1'b0) r = -1;
      if (r >= 0) begin
        if (lo[j] === 1'b1) r += (1 << (2 * j + 1));
        else if (lo[j] !== 1'b0) r = -1;
      end
      if (r < 0) return -1;
    end
    return r;
  endfunction

  initial begin
    logic [DW-1:0] hi0, hi1, lo0, lo1;
    int            cnt_a;
    exp_t          e;
    forever begin
      @(posedge aclk);
      #1;
      hi0   = dac_dat_out_0;
      hi1   = dac_dat_out_1;
      cnt_a = (^underflow_count === 1'bx) ? -1 : int'(underflow_count);
      @(negedge aclk);
      #1;
      lo0 = dac_dat_out_0;
      lo1 = dac_dat_out_1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("ch0_pins", reassemble(hi0, lo0), e.s0);
        check("ch1_pins", reassemble(hi1, lo1), e.s1);
        check("underflow_count", cnt_a, e.cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    areset        = 1'b1;
    cfg_mode      = 2'd0;
    cnt_clear     = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = $urandom;

    // Reset held 3 cycles with a valid beat offered.
    run(3);
    areset = 1'b0;

    // Known beat; bits outside the two W-bit fields are set to be ignored.
    s_axis_tdata = {2'b11, 14'h1234, 2'b10, 14'h2A55};
    cycle();

    // Random beats with random gaps.
    for (int k = 0; k < 40; k++) begin
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      s_axis_tdata  = $urandom;
      cycle();
    end

    // Clear, then 0x0100 followed by 5 underflows, then clear on an underflow.
    cnt_clear = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = $urandom;
    cycle();
    cnt_clear = 1'b0; s_axis_tdata = {16'h0ABC, 16'h0100};
    cycle();
    s_axis_tvalid = 1'b0; s_axis_tdata = $urandom;
    run(5);
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;

    // Long starvation: counter must saturate, not wrap.
    run(70000);
    s_axis_tvalid = 1'b1; s_axis_tdata = $urandom;
    cycle();
    cnt_clear = 1'b1; s_axis_tvalid = 1'b0;
    cycle();
    cnt_clear = 1'b0;

    // MIDSCALE -> full RAMP wrap -> TOGGLE -> MIDSCALE.
    cfg_mode = 2'd3; run(3);
    cfg_mode = 2'd1; run((1 << W) + 3);
    cfg_mode = 2'd2; run(6);
    cfg_mode = 2'd3; run(3);

    // Reset mid-RAMP once 0x0123 has been loaded.
    cfg_mode = 2'd1; run(16'h0124);
    areset = 1'b1; s_axis_tvalid = 1'b1; run(2);
    areset = 1'b0; run(6);

    // Random mode switching (clear pulses only while streaming).
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0) cfg_mode = 2'($urandom_range(0, 3));
      s_axis_tvalid = ($urandom_range(0, 2) != 0);
      s_axis_tdata  = $urandom;
      cnt_clear     = (cfg_mode == 2'd0) && ($urandom_range(0, 9) == 0);
      cycle();
    end
    cnt_clear = 1'b0;

    @(negedge aclk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axis_red_pitaya_dac_ddr.md
# axis_red_pitaya_dac_ddr

Transmit-side counterpart of the Red Pitaya ADC DDR capture path: accepts two-channel sample pairs on an AXI4-Stream slave, or generates built-in test patterns, and drives each DAC channel as a half-width DDR bus. Each sample is split so that even bits go out on the rising edge and odd bits on the falling edge. This is the same bit ordering the ADC receiver uses when it reassembles samples. The block sits between the DSP/stream fabric and the DAC pins and reports stream underflows.

## Interface
Parameters:
- DDR_DATA_WIDTH, 7, pins per channel; sample width W = 2*DDR_DATA_WIDTH, which must be at most 16.

Ports:
- aclk  in  1  single clock; all logic is on the rising edge.
- areset  in  1  synchronous, active-high reset.
- cfg_mode  in  2  source select: 0 STREAM, 1 RAMP, 2 TOGGLE, 3 MIDSCALE.
- cnt_clear  in  1  single-cycle pulse that clears underflow_count.
- s_axis_tdata  in  32  [W-1:0] is the ch0 sample; [16+W-1:16] is the ch1 sample; all other bits are ignored.
- s_axis_tvalid  in  1  stream valid.
- s_axis_tready  out  1  stream ready.
- dac_dat_out_0  out  DDR_DATA_WIDTH  ch0 DDR pins.
- dac_dat_out_1  out  DDR_DATA_WIDTH  ch1 DDR pins.
- underflow_count  out  16  number of cycles in STREAM mode with no sample accepted; saturates at 0xFFFF.

## Operation
- Stage S1 is the sample register pair smp[0], smp[1], loaded every cycle. Its source depends on cfg_mode:
  - STREAM: on a beat (tvalid and tready), smp is loaded from tdata.
  - STREAM with tvalid low: smp holds its previous value and underflow_count increments, saturating.
  - RAMP: smp[0] is a W-bit counter that increments by 1 every cycle and wraps from 2^W-1 to 0. smp[1] = ~smp[0].
  - TOGGLE: smp[0] alternates each cycle between the 1010… value (0x2AAA at W=14) and the 0101… value (0x1555). smp[1] is always the opposite value.
  - MIDSCALE: both channels are 1<<(W-1), which is 0x2000 at W=14.
- s_axis_tready = (cfg_mode == STREAM) && !areset. No internal buffering, so one beat is consumed per cycle while ready is high.
- Stage S2 splits each sample into two registered halves:
  - rise[i][j] = smp[i][2j]
  - fall[i][j] = smp[i][2j+1]
- Each pin is driven by an ODDR primitive:
  - DDR_CLK_EDGE = SAME_EDGE, SRTYPE = SYNC.
  - D1 = rise, D2 = fall, C = aclk, CE = 1, R = areset, S = 0.
- Mode changes take effect at the next S1 load with no glitch cycle.
- The ramp counter and the toggle phase restart from 0 / 1010… whenever their mode is entered from another mode.
- underflow_count changes only in STREAM mode.
- cnt_clear coinciding with an underflow: clear wins, and the count reads 0 on the next cycle.
- Reset:
  - smp, rise, fall, ramp counter and toggle phase are all cleared to 0.
  - underflow_count = 0, s_axis_tready = 0, and both DAC buses drive 0 on both edges.
  - This holds when reset is asserted mid-stream; the beat offered in the reset cycle is not accepted.

## Timing
- Latency: a beat accepted at edge N is in smp after edge N and in rise/fall after edge N+1.
- The ODDR registers it at edge N+2. The rise half appears on the pins during the high phase following edge N+2, and the fall half during the following low phase.
- Pattern modes have the same latency, measured from the cycle that loads S1.
- The first underflow cycle increments the count, visible one cycle later.
- Throughput is one sample pair per aclk cycle, continuously.

## Structure
- Package red_pitaya_dac_pkg holds:
  - the mode constants MODE_STREAM, MODE_RAMP, MODE_TOGGLE, MODE_MIDSCALE;
  - the 16-bit counter width;
  - the toggle pattern functions, parameterised by W.
- Sub-module dac_pattern_gen (parameter W) contains the ramp counter and toggle phase register. It takes aclk, areset and cfg_mode and outputs pat_0 and pat_1; its restart-on-mode-entry logic lives there.
- The top level contains the stream handshake, the S1/S2 registers, the underflow counter and the ODDR generate loop.

## Test plan
- Reset held for 3 cycles while tvalid = 1: tready = 0, pins stay 0 on both edges, and underflow_count = 0 after release.
- STREAM, W=14, beats ch0 = 0x2A55 and ch1 = 0x1234 accepted at edge N: after N+2, pins carry the even bits of 0x2A55 on the high phase and the odd bits on the low phase. A model that reassembles Q1/Q2 recovers 0x2A55 and 0x1234.
- STREAM with tvalid low for 5 cycles after sample 0x0100: the output holds 0x0100 and underflow_count = 5. After that, cnt_clear asserted in the same cycle as an underflow gives a count of 0.
- STREAM with tvalid held low for 70000 cycles: underflow_count saturates at 0xFFFF with no wrap.
- RAMP entered from MIDSCALE: the reassembled ch0 sequence is 0,1,2,…,0x3FFF,0 with ch1 = ~ch0. Switching to TOGGLE gives 0x2AAA/0x1555 alternating, then MIDSCALE gives 0x2000 on both channels.
- Reset asserted mid-RAMP at value 0x0123: the pins return to 0 and the ramp restarts at 0 after release.
